// File: rtl/match_controller.sv
// match_controller: top-level Pong match sequencer.
// Runs attract / serve countdown / rally / point pause / game over, keeps both
// scores, chooses the serve direction and drives the ball/paddle controls.
// Every output comes straight from a register; inputs are sampled once before use.
module match_controller #(
  parameter int CLK_FREQ       = 25_175_000,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int POINT_DELAY_MS = 500,
  parameter int WIN_SCORE      = 7,
  parameter int SCORE_W        = 4
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               sq_missed,
  input  logic               miss_side,
  output logic               reset_game,
  output logic               ball_enable,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SERVE     = 3'd1;
  localparam logic [2:0] RALLY     = 3'd2;
  localparam logic [2:0] POINT     = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  localparam int SERVE_CYC = CLK_FREQ / 1000 * SERVE_DELAY_MS;
  localparam int POINT_CYC = CLK_FREQ / 1000 * POINT_DELAY_MS;
  localparam int MAX_CYC   = (SERVE_CYC > POINT_CYC) ? SERVE_CYC : POINT_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_CYC - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_CYC - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  // Sampled inputs: *_s is the current sample, *_q the previous one.
  // The button pairs reset high so a button held through reset is not an edge.
  logic start_s, start_q;
  logic pause_s, pause_q;
  logic missed_s, side_s;

  logic             paused;
  logic [CNT_W-1:0] cnt;

  logic start_edge, pause_edge;

  logic [2:0]         state_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               paused_n;
  logic [SCORE_W-1:0] score_l_n, score_r_n;
  logic               serve_dir_n, winner_n;
  logic [SCORE_W-1:0] hit_score, hit_next;
  logic               reset_game_n, ball_enable_n, game_over_n;

  assign start_edge = start_s & ~start_q;
  assign pause_edge = pause_s & ~pause_q;

  // Next-state and datapath decisions for the match sequencer.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    paused_n    = paused;
    score_l_n   = score_l;
    score_r_n   = score_r;
    serve_dir_n = serve_dir;
    winner_n    = winner;
    hit_score   = side_s ? score_l : score_r;
    hit_next    = (hit_score < WIN_VAL) ? hit_score + 1'b1 : hit_score;

    case (state)
      IDLE, GAME_OVER: begin
        if (start_edge) begin
          state_n     = SERVE;
          cnt_n       = '0;
          paused_n    = 1'b0;
          score_l_n   = '0;
          score_r_n   = '0;
          serve_dir_n = 1'b0;
          winner_n    = 1'b0;
        end
      end

      SERVE: begin
        if (cnt == SERVE_LAST) begin
          state_n = RALLY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RALLY: begin
        if (missed_s) begin
          if (side_s) begin
            score_l_n = hit_next;
          end else begin
            score_r_n = hit_next;
          end
          serve_dir_n = side_s;
          paused_n    = 1'b0;
          cnt_n       = '0;
          if (hit_next == WIN_VAL) begin
            state_n  = GAME_OVER;
            winner_n = ~side_s;
          end else begin
            state_n = POINT;
          end
        end else if (pause_edge) begin
          paused_n = ~paused;
        end
      end

      POINT: begin
        if (cnt == POINT_LAST) begin
          state_n = SERVE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    reset_game_n  = (state_n == IDLE) || (state_n == SERVE);
    ball_enable_n = (state_n == RALLY) && !paused_n;
    game_over_n   = (state_n == GAME_OVER);
  end

  // Register input samples, match state and the decoded outputs together.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      start_s     <= 1'b1;
      start_q     <= 1'b1;
      pause_s     <= 1'b1;
      pause_q     <= 1'b1;
      missed_s    <= 1'b0;
      side_s      <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      paused      <= 1'b0;
      score_l     <= '0;
      score_r     <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      reset_game  <= 1'b1;
      ball_enable <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      start_s     <= start_btn;
      start_q     <= start_s;
      pause_s     <= pause_btn;
      pause_q     <= pause_s;
      missed_s    <= sq_missed;
      side_s      <= miss_side;
      state       <= state_n;
      cnt         <= cnt_n;
      paused      <= paused_n;
      score_l     <= score_l_n;
      score_r     <= score_r_n;
      serve_dir   <= serve_dir_n;
      winner      <= winner_n;
      reset_game  <= reset_game_n;
      ball_enable <= ball_enable_n;
      game_over   <= game_over_n;
    end
  end

endmodule

// File: doc/match_controller.md
# match_controller

Top-level game sequencer for the Pong engine. It runs the match state machine (attract, serve countdown, rally, point pause, game over), keeps both scores, and decides the serve direction. It drives the `reset_game` / `ball_enable` controls consumed by the ball, player-paddle and AI-opponent datapaths. It consumes the single-cycle `sq_missed` event from the ball logic and debounced button levels from the input block.

## Interface
Parameters:
- `CLK_FREQ`, 25_175_000, clock frequency in Hz.
- `SERVE_DELAY_MS`, 1000, countdown length before each serve.
- `POINT_DELAY_MS`, 500, freeze length after a point is scored.
- `WIN_SCORE`, 7, score that ends the match; must be < 2^`SCORE_W`.
- `SCORE_W`, 4, width of each score counter.

Ports:
- `clk_0`  in  1  pixel clock. One clock domain only.
- `rst`  in  1  reset. Synchronous and active-low.
- `start_btn`  in  1  debounced level; acted on at its rising edge only.
- `pause_btn`  in  1  debounced level; acted on at its rising edge only.
- `sq_missed`  in  1  one-cycle pulse when the ball reaches the left or right edge.
- `miss_side`  in  1  valid with `sq_missed`. 0 = exited left (AI scores). 1 = exited right (player scores).
- `reset_game`  out  1  paddles and ball recentre while high.
- `ball_enable`  out  1  ball may move while high.
- `serve_dir`  out  1  launch direction for the next serve. 0 = toward player (left). 1 = toward AI (right).
- `score_l`  out  `SCORE_W`  player score.
- `score_r`  out  `SCORE_W`  AI score.
- `game_over`  out  1  high in GAME_OVER.
- `winner`  out  1  valid while `game_over` is high. 0 = player. 1 = AI.
- `state`  out  3  current state encoding, for the HUD and debug.

## Operation
- States: IDLE=0, SERVE=1, RALLY=2, POINT=3, GAME_OVER=4. Codes 5–7 are illegal and go to IDLE on the next clock.
- Edge detect: `start_q`/`pause_q` hold the previous sample. An edge is `btn & ~btn_q`. Both registers reset to 1, so a button held through reset produces no edge.
- IDLE:
  - `reset_game`=1, `ball_enable`=0.
  - A start edge moves to SERVE, clears both scores, sets `serve_dir`=0 and clears the delay counter.
- SERVE:
  - `reset_game`=1, `ball_enable`=0.
  - The delay counter runs 0..SERVE_CYC−1, where SERVE_CYC = CLK_FREQ/1000·SERVE_DELAY_MS.
  - At terminal count: go to RALLY and clear the counter.
- RALLY:
  - `reset_game`=0, `ball_enable`=~`paused`.
  - A pause edge toggles `paused`.
  - On `sq_missed`: increment `score_l` if `miss_side`=1, else `score_r`. Set `serve_dir`=`miss_side`, clear `paused` and the counter.
  - If the incremented score equals WIN_SCORE, go to GAME_OVER with `winner`=~`miss_side`. Otherwise go to POINT.
  - If `sq_missed` and a pause edge arrive in the same cycle, the miss takes priority and the pause edge is dropped.
- POINT:
  - `reset_game`=0, `ball_enable`=0.
  - Counts POINT_CYC = CLK_FREQ/1000·POINT_DELAY_MS cycles, then goes to SERVE with the counter cleared.
- GAME_OVER:
  - `reset_game`=0, `ball_enable`=0, `game_over`=1. Scores are frozen.
  - A start edge goes to SERVE: clear scores, `winner`, `paused`; set `serve_dir`=0.
- Ignored events:
  - A start edge outside IDLE and GAME_OVER.
  - A pause edge outside RALLY.
  - `sq_missed` outside RALLY.
- Scores never exceed WIN_SCORE and never wrap.
- The delay counter is `$clog2(max(SERVE_CYC,POINT_CYC)+1)` bits wide and unsigned. The terminal compare is `==`, with no overflow.

## Timing
- Reset values (during reset and on the first clock after release):
  - `state`=IDLE.
  - `reset_game`=1.
  - `ball_enable`=0, `serve_dir`=0.
  - `score_l`=0, `score_r`=0.
  - `game_over`=0, `winner`=0.
  - `paused`=0, counter=0.
- All outputs are registered. Each is a pure function of the registered state and flags, with no combinational path from input to output.
- A button sampled high at edge n, after low at n−1, changes `state` at edge n+1.
- `sq_missed` sampled at edge n: the score update and new state are visible after edge n+1.
- SERVE lasts exactly SERVE_CYC cycles and POINT lasts exactly POINT_CYC cycles.
- Reset asserted mid-operation: on the next edge every register takes its reset value. No partial score is retained.

## Test plan
Bench parameters: CLK_FREQ=1000, SERVE_DELAY_MS=4, POINT_DELAY_MS=2, WIN_SCORE=3.
- **Reset with button held:** hold `rst`=0 with `start_btn`=1, then release with the button still held. Required: `state` stays 0, `reset_game`=1, scores 0, no transition.
- **Start and serve:** start edge, then count cycles. Required: SERVE lasts exactly 4 cycles, then RALLY with `ball_enable`=1 and `reset_game`=0.
- **Player point:** `sq_missed`=1 with `miss_side`=1 in RALLY. Required: `score_l`=1, `serve_dir`=1, POINT lasts 2 cycles, then SERVE lasts 4 cycles, then RALLY.
- **Pause:** pause edge in RALLY makes `ball_enable`=0 and a second edge restores it. Then pause edge and `sq_missed`(`miss_side`=0) in the same cycle. Required: `score_r` increments, `paused`=0, state POINT.
- **AI wins:** three misses with `miss_side`=0. Required: `score_r`=3, `game_over`=1, `winner`=1. A further `sq_missed` leaves the scores unchanged. A start edge clears the scores and enters SERVE with `serve_dir`=0.
- **Reset mid-rally:** assert `rst` mid-RALLY with score 2–1. Required: all outputs return to their reset values on the next clock.
